div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative 32-step restoring divider for the execute stage.
//
// Signed or unsigned divide. Operands are sampled once, when a request is
// accepted, and are not read again. The divider then produces one quotient
// bit per cycle from the operand magnitudes. The signs of the quotient and
// remainder are fixed up on the final step.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = two's-complement divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is seen
//   annul_i       abort the current divide
//   result_o      {remainder, quotient}, zero unless ready_o is high
//   ready_o       result_o is valid
module div_unit #(
  parameter int DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [DIV_W-1:0]   opdata1_i,
  input  logic [DIV_W-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*DIV_W-1:0] result_o,
  output logic               ready_o
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  localparam int CW = $clog2(DIV_W);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [DIV_W-1:0] rem;      // partial remainder
  logic [DIV_W-1:0] quo;      // dividend bits shift out, quotient bits shift in
  logic [DIV_W-1:0] dvs;      // divisor magnitude
  logic             neg_quo;
  logic             neg_rem;

  // Operand magnitudes and sign flags, used only on the accepting edge.
  logic             a_neg;
  logic             b_neg;
  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;

  always_comb begin
    a_neg = signed_div_i & opdata1_i[DIV_W-1];
    b_neg = signed_div_i & opdata2_i[DIV_W-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
  end

  // One restoring step: bring down the next dividend bit and compare the
  // resulting 33-bit partial remainder against the divisor. Whenever the
  // subtraction is taken, the difference is below the divisor, so the low
  // DIV_W bits of the difference are exact.
  logic [DIV_W:0]   shifted;
  logic             take;
  logic [DIV_W-1:0] diff;
  logic [DIV_W-1:0] rem_next;
  logic [DIV_W-1:0] quo_next;

  always_comb begin
    shifted  = {rem, quo[DIV_W-1]};
    take     = (shifted >= {1'b0, dvs});
    diff     = shifted[DIV_W-1:0] - dvs;
    rem_next = take ? diff : shifted[DIV_W-1:0];
    quo_next = {quo[DIV_W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              rem     <= '0;
              quo     <= a_mag;
              dvs     <= b_mag;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
            end
          end
        end

        BYZERO: begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end

        ON: begin
          if (annul_i || !start_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            // The last step registers the result directly from the step
            // outputs, so no extra cycle is spent on the sign fix-up.
            if (cnt == CW'(DIV_W - 1)) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {(neg_rem ? -rem_next : rem_next),
                           (neg_quo ? -quo_next : quo_next)};
            end
          end
        end

        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed self-checking bench for div_unit.
//
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point. Latency is counted in edges, including the edge that
// accepts the request.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and hold start until ready is seen. Once the operands
  // have been accepted, they are scrambled. The task then checks the latency,
  // the result, that the result holds for one more cycle, and that the
  // outputs clear on exit (the exit is through start=0 or through annul).
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int unsigned exp_lat, input logic exit_annul);
    int unsigned n;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    annul      = 1'b0;
    n          = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        op1        = $urandom;
        op2        = $urandom;
        signed_div = ~sgn;
      end
    end while (!ready && n < 40);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    tick();
    check({tag, " ready hold"}, 64'(ready), 64'd1);
    check({tag, " result hold"}, result, exp_res);
    if (exit_annul) annul = 1'b1;
    else            start = 1'b0;
    tick();
    check({tag, " ready clear"}, 64'(ready), 64'd0);
    check({tag, " result clear"}, result, 64'd0);
    start = 1'b0;
    annul = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;

    // A request held during reset must be ignored.
    repeat (3) tick();
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;

    // The first edge after reset release accepts the request, and the
    // following calls run back to back.
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
    run_div("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    run_div("uFFFF_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1'b0);
    run_div("uFFF9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 33, 1'b0);
    run_div("byzero", 1'b1, 32'd1234, 32'd0, 64'd0, 2, 1'b1);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b1);

    // Annul at step 10 of ON.
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    tick();
    check("annul ready", 64'(ready), 64'd0);
    check("annul result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();
    check("annul idle ready", 64'(ready), 64'd0);
    run_div("post_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);

    // Dropping start mid-ON abandons the divide.
    op1   = 32'd5;
    op2   = 32'd3;
    start = 1'b1;
    tick();
    repeat (5) tick();
    start = 1'b0;
    tick();
    check("drop ready", 64'(ready), 64'd0);
    tick();
    check("drop idle ready", 64'(ready), 64'd0);

    // Reset at step 20 of ON.
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst result", result, 64'd0);
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
